// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction fetch unit
package if_pkg;

  localparam int          XLEN           = 32;
  localparam int          IF_DATA_LENGTH = 32;
  localparam logic [31:0] IF_RESET_PC    = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]           pc;
    logic [IF_DATA_LENGTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_queue.sv
// rtl/if_fetch_unit_queue.sv - synchronous fetch FIFO with flush priority over push/pop
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push at full is legal only when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop_ok) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i && push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - PC owner and I-cache request driver feeding decode through a fetch queue
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int          DATA_LENGTH = 32,
  parameter logic [31:0] RESET_PC    = IF_RESET_PC,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [31:0]            ic_addr,
  output logic                   ic_req,
  input  logic [DATA_LENGTH-1:0] ic_data,
  input  logic                   ic_hit,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   inst_valid,
  output logic [DATA_LENGTH-1:0] inst_data,
  output logic [31:0]            inst_pc,
  input  logic                   id_ready
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int EW = XLEN + DATA_LENGTH;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  saved_q, saved_d;
  logic         discard_q, discard_d;

  logic          q_push, q_pop, q_flush, q_full, q_empty;
  logic [CW-1:0] q_count;
  logic [EW-1:0] q_head;
  logic          hit_acc;

  assign ic_addr    = pc_q;
  assign ic_req     = !rst && ((state_q == WAIT) || (q_count < CW'(QUEUE_DEPTH)));
  assign hit_acc    = ic_req && ic_hit;
  assign inst_valid = !rst && !q_empty;
  assign q_pop      = inst_valid && id_ready;
  assign inst_pc    = q_head[EW-1:DATA_LENGTH];
  assign inst_data  = q_head[DATA_LENGTH-1:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    saved_d   = saved_q;
    discard_d = discard_q;
    q_push    = 1'b0;
    q_flush   = 1'b0;
    if (redirect_valid) begin
      q_flush = 1'b1;
      // A miss in flight keeps its address; the target is applied once the line returns.
      if (state_q == WAIT && !ic_hit) begin
        saved_d   = redirect_pc & ~32'd3;
        discard_d = 1'b1;
      end else begin
        pc_d      = redirect_pc & ~32'd3;
        discard_d = 1'b0;
        state_d   = IDLE;
      end
    end else if (hit_acc) begin
      state_d = IDLE;
      if (discard_q) begin
        pc_d      = saved_q;
        discard_d = 1'b0;
      end else begin
        q_push = !q_full || q_pop;
        pc_d   = pc_q + 32'd4;
      end
    end else if (ic_req) begin
      state_d = WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      saved_q   <= RESET_PC;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      saved_q   <= saved_d;
      discard_q <= discard_d;
    end
  end

  fetch_queue #(
    .WIDTH (EW),
    .DEPTH (QUEUE_DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (q_flush),
    .push_i      (q_push),
    .push_data_i ({pc_q, ic_data}),
    .pop_i       (q_pop),
    .head_o      (q_head),
    .count_o     (q_count),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ic_addr;
  logic        ic_req;
  logic [31:0] ic_data;
  logic        ic_hit;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        id_ready;

  int passed = 0;
  int total  = 0;
  int pushes;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .DATA_LENGTH (32),
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ic_addr        (ic_addr),
    .ic_req         (ic_req),
    .ic_data        (ic_data),
    .ic_hit         (ic_hit),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .id_ready       (id_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ic_hit = 1'b0; ic_data = '0; id_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    chk("rst_req", {31'd0, ic_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_addr", ic_addr, 32'h0);
    chk("post_rst_req", {31'd0, ic_req}, 32'd1);

    // Streaming hits with decode ready.
    ic_hit = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("stream_addr", ic_addr, 32'(4 * i));
      if (i > 0) begin
        chk("stream_valid", {31'd0, inst_valid}, 32'd1);
        chk("stream_pc", inst_pc, 32'(4 * (i - 1)));
        chk("stream_data", inst_data, 32'hA000_0000 + 32'(4 * (i - 1)));
      end
      ic_data = 32'hA000_0000 + 32'(4 * i);
      step();
    end

    // Miss held for five cycles at 0x40.
    ic_hit = 1'b0;
    redir(32'h40);
    chk("flush_valid", {31'd0, inst_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("miss_addr", ic_addr, 32'h40);
      chk("miss_req", {31'd0, ic_req}, 32'd1);
      step();
    end
    ic_hit = 1'b1; ic_data = 32'hDEAD_BEEF; id_ready = 1'b0;
    chk("miss_addr_hit", ic_addr, 32'h40);
    step();
    chk("miss_valid", {31'd0, inst_valid}, 32'd1);
    chk("miss_pc", inst_pc, 32'h40);
    chk("miss_data", inst_data, 32'hDEAD_BEEF);
    chk("miss_next_addr", ic_addr, 32'h44);

    // Fill the queue with decode stalled.
    ic_hit = 1'b0;
    redir(32'h100);
    ic_hit = 1'b1; pushes = 0;
    for (int i = 0; i < 8; i++) begin
      ic_data = 32'hB000_0000 | ic_addr;
      if (ic_req && ic_hit) pushes++;
      step();
    end
    chk("fill_pushes", 32'(pushes), 32'd4);
    chk("fill_req", {31'd0, ic_req}, 32'd0);
    chk("fill_head_pc", inst_pc, 32'h100);
    chk("fill_head_data", inst_data, 32'hB000_0100);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk("pop_head_pc", inst_pc, 32'h104);
    chk("pop_req", {31'd0, ic_req}, 32'd1);
    chk("pop_addr", ic_addr, 32'h110);
    ic_data = 32'hB000_0110;
    step();
    chk("refill_req", {31'd0, ic_req}, 32'd0);
    chk("stall_pc", inst_pc, 32'h104);
    chk("stall_data", inst_data, 32'hB000_0104);

    // Redirect in IDLE with two entries queued.
    ic_hit = 1'b0;
    redir(32'h2000);
    ic_hit = 1'b1;
    step(); step();
    ic_hit = 1'b0;
    chk("two_valid", {31'd0, inst_valid}, 32'd1);
    redir(32'h1003);
    chk("idle_redir_valid", {31'd0, inst_valid}, 32'd0);
    chk("idle_redir_addr", ic_addr, 32'h1000);

    // Redirects during an outstanding miss.
    redir(32'h80);
    step();
    chk("wait_addr0", ic_addr, 32'h80);
    redir(32'h200);
    chk("wait_addr1", ic_addr, 32'h80);
    redir(32'h300);
    chk("wait_addr2", ic_addr, 32'h80);
    chk("wait_req", {31'd0, ic_req}, 32'd1);
    step();
    chk("wait_addr3", ic_addr, 32'h80);
    ic_hit = 1'b1; ic_data = 32'h0000_0BAD;
    step();
    chk("discard_valid", {31'd0, inst_valid}, 32'd0);
    chk("discard_addr", ic_addr, 32'h300);

    // Redirect colliding with a hit.
    ic_hit = 1'b0;
    redir(32'h90);
    chk("collide_pre_addr", ic_addr, 32'h90);
    ic_hit = 1'b1; ic_data = 32'h0000_0090;
    redir(32'h500);
    chk("collide_valid", {31'd0, inst_valid}, 32'd0);
    chk("collide_addr", ic_addr, 32'h500);
    id_ready = 1'b1; ic_data = 32'h0000_0500;
    step();
    chk("collide_pc", inst_pc, 32'h500);
    chk("collide_next", ic_addr, 32'h504);

    // PC wrap and low-bit masking.
    ic_hit = 1'b0;
    redir(32'hFFFF_FFFF);
    chk("wrap_addr", ic_addr, 32'hFFFF_FFFC);
    ic_hit = 1'b1; ic_data = 32'h1234_5678;
    step();
    chk("wrap_next", ic_addr, 32'h0);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);

    // Reset while a miss is outstanding.
    ic_hit = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rst_wait_req", {31'd0, ic_req}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_wait_addr", ic_addr, 32'h0);
    chk("rst_wait_valid", {31'd0, inst_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Upstream feeder of the IF-stage instruction cache.
- Owns the PC and drives the cache's address/request pair. Holds the request stable across cache misses.
- Buffers returned instructions, tagged with their PC, in a small queue that feeds decode over a valid/ready handshake.
- Handles branch/exception redirects from later stages, including redirects that arrive while a miss is outstanding.

Parameters:
- DATA_LENGTH, 32, instruction width in bits.
- RESET_PC, 32'h0000_0000, PC loaded on reset. Word aligned.
- QUEUE_DEPTH, 4, fetch-queue entries. Power of two, minimum 2.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ic_addr  out  32  fetch address to the instruction cache.
- ic_req  out  1  fetch request to the instruction cache.
- ic_data  in  DATA_LENGTH  instruction word from the cache. Valid when ic_hit=1.
- ic_hit  in  1  cache hit/return. Combinational in the cycle the line is present.
- redirect_valid  in  1  redirect request from EX/commit.
- redirect_pc  in  32  redirect target. Bits [1:0] are ignored and forced to 0.
- inst_valid  out  1  queue head valid toward decode.
- inst_data  out  DATA_LENGTH  head instruction.
- inst_pc  out  32  PC of the head instruction.
- id_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset is synchronous and active-high:
  - pc <= RESET_PC; queue emptied (count=0); state <= IDLE; discard <= 0.
  - While rst=1: ic_req=0 and inst_valid=0.
- State machine has two states:
  - IDLE: no request outstanding.
  - WAIT: request issued, no hit yet.
- ic_addr = pc in all states.
- ic_req = (state==WAIT) | (state==IDLE & count<QUEUE_DEPTH).
  - A pop in the same cycle does not count as free space.
- Once ic_req=1 with ic_hit=0, state <= WAIT.
  - While in WAIT, ic_addr and ic_req hold constant until ic_hit=1, because the cache uses the address throughout its miss/refill.
- Hit in a cycle with ic_req=1 & ic_hit=1:
  - If discard=0 and no redirect this cycle: push {pc, ic_data}; pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0); state <= IDLE.
  - If discard=1: drop ic_data; pc <= saved_target; discard <= 0; state <= IDLE.
- Redirect:
  - Queue is flushed (count=0) in the cycle redirect_valid=1. A simultaneous pop is ignored.
  - IDLE, or a hit in the same cycle: drop any hit data; pc <= redirect_pc & ~3.
  - WAIT with no hit: saved_target <= redirect_pc & ~3; discard <= 1; pc unchanged; ic_addr stays on the old address.
  - Repeated redirects during WAIT overwrite saved_target. The newest target wins.
- Latency:
  - A cache hit in cycle N gives inst_valid=1 in cycle N+1.
  - Sustained throughput is 1 instruction/cycle on hits with decode ready.
- Queue:
  - Push only on an accepted hit. Pop when inst_valid & id_ready.
  - Simultaneous push and pop leaves count unchanged and is allowed at full.
  - A request is only started when count<QUEUE_DEPTH, and at most one request is outstanding. The queue therefore cannot overflow; the bench asserts this.
  - inst_data and inst_pc are stable while inst_valid=1 and id_ready=0.
- Pointers wrap modulo QUEUE_DEPTH.
- count width is clog2(QUEUE_DEPTH)+1.
- rst during WAIT aborts tracking. ic_req drops the same cycle. The cache owner is responsible for resetting alongside.

Decomposition:
- Package if_pkg holds:
  - XLEN=32.
  - IF_RESET_PC.
  - The fetch-state encoding (IDLE=1'b0, WAIT=1'b1).
  - The fetch_entry_t struct {pc[31:0], inst[DATA_LENGTH-1:0]}.
- Sub-module fetch_queue: synchronous FIFO with push, pop, flush, count, full and empty. Flush has priority over push and pop.
- The top level holds the PC, the state machine and the redirect/discard logic.

Test Plan:
- Reset then constant ic_hit=1, id_ready=1 -> ic_addr 0,4,8,C on consecutive cycles; inst_pc 0,4,8 from cycle 2; inst_valid continuous.
- ic_hit=0 for 5 cycles at pc=0x40, then hit with ic_data=0xDEADBEEF -> ic_addr held at 0x40 for all 6 cycles; one entry {0x40, 0xDEADBEEF}; next ic_addr=0x44.
- id_ready=0, hits every cycle -> exactly 4 pushes; ic_req=0 while count=4. Then id_ready=1 for one cycle -> one pop, ic_req resumes, no overflow.
- Redirect to 0x1003 while IDLE with 2 entries queued -> queue empty next cycle; next ic_addr=0x1000.
- In WAIT at 0x80: redirect to 0x200, then to 0x300, then hit -> hit data discarded, nothing pushed; ic_addr held at 0x80 until the hit, then 0x300.
- Redirect to 0x500 in the same cycle as a hit at 0x90 -> 0x90 not pushed; queue empty; next ic_addr=0x500.
